// File: rtl/pitch_readback_interface_if.sv
// rtl/pitch_readback_interface_if.sv - Avalon read bus and hardware push port of the pitch readback block
interface pitch_readback_interface_if;
    logic        chipselect;
    logic        read;
    logic [2:0]  address;
    logic [7:0]  readdata;
    logic [15:0] push_data;
    logic        push_valid;
    logic        fifo_full;
    logic        irq;

    modport master (
        output chipselect, read, address, push_data, push_valid,
        input  readdata, fifo_full, irq
    );

    modport slave (
        input  chipselect, read, address, push_data, push_valid,
        output readdata, fifo_full, irq
    );
endinterface

// File: rtl/pitch_readback_interface.sv
// rtl/pitch_readback_interface.sv - FIFO of 16-bit hardware results drained over an 8-bit Avalon read slave
// Optional dropped-word counter at address 4 enabled by PITCH_READBACK_DROPCNT_EN.
module pitch_readback_interface #(
    parameter int DEPTH      = 16,
    parameter int IRQ_THRESH = 8
) (
    input  logic clk,
    input  logic reset,
    pitch_readback_interface_if.slave bus
);
    localparam int         PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] DEPTH_C  = 8'(DEPTH);
    localparam logic [7:0] THRESH_C = 8'(IRQ_THRESH);

    logic [15:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [7:0]       count;
    logic [7:0]       count_next;
    logic             overflow;
    logic             overflow_next;
    logic [7:0]       readdata_q;
    logic [7:0]       readdata_next;
    logic             irq_q;
    logic [7:0]       drop_cnt;

    logic        rd_access;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push_accept;
    logic        drop;
    logic        status_clear;
    logic        dropcnt_clear;
    logic [15:0] head;

    assign rd_access     = bus.chipselect && bus.read;
    assign empty         = (count == 8'd0);
    assign full          = (count == DEPTH_C);
    assign pop           = rd_access && (bus.address == 3'd1) && !empty;
    // A simultaneous pop frees the slot, so a push at full is still accepted.
    assign push_accept   = bus.push_valid && (!full || pop);
    assign drop          = bus.push_valid && full && !pop;
    assign status_clear  = rd_access && (bus.address == 3'd3);
    assign dropcnt_clear = rd_access && (bus.address == 3'd4);
    assign head          = mem[rd_ptr];

    assign bus.readdata  = readdata_q;
    assign bus.irq       = irq_q;
    assign bus.fifo_full = full;

    always_comb begin
        count_next = count;
        case ({push_accept, pop})
            2'b10:   count_next = count + 8'd1;
            2'b01:   count_next = count - 8'd1;
            default: count_next = count;
        endcase
    end

    always_comb begin
        overflow_next = overflow;
        if (drop)
            overflow_next = 1'b1;
        else if (status_clear)
            overflow_next = 1'b0;
    end

    always_comb begin
        readdata_next = readdata_q;
        if (rd_access) begin
            case (bus.address)
                3'd0:    readdata_next = empty ? 8'h00 : head[7:0];
                3'd1:    readdata_next = empty ? 8'h00 : head[15:8];
                3'd2:    readdata_next = count;
                3'd3:    readdata_next = {5'b0, overflow, full, empty};
                3'd4:    readdata_next = drop_cnt;
                default: readdata_next = 8'h00;
            endcase
        end
    end

    // Storage is deliberately left out of reset; only pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push_accept)
            mem[wr_ptr] <= bus.push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= 8'd0;
            overflow   <= 1'b0;
            readdata_q <= 8'h00;
            irq_q      <= 1'b0;
        end else begin
            if (push_accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count      <= count_next;
            overflow   <= overflow_next;
            readdata_q <= readdata_next;
            irq_q      <= (count_next >= THRESH_C);
        end
    end

`ifdef PITCH_READBACK_DROPCNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            drop_cnt <= 8'h00;
        else if (drop && dropcnt_clear)
            drop_cnt <= 8'h01;
        else if (dropcnt_clear)
            drop_cnt <= 8'h00;
        else if (drop && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'd1;
    end
`else
    logic unused_clear;
    assign unused_clear = dropcnt_clear;
    assign drop_cnt     = 8'h00;
`endif
endmodule
